// File: rtl/bar_pattern_sequencer.sv
// bar_pattern_sequencer: stepping thermometer / one-hot bar-graph generator.
// A prescaler produces a tick every DIV enabled cycles. Each tick advances
// the level according to the sampled mode (up-wrap, down-wrap, ping-pong, hold).
// The pattern is rebuilt every edge from the next level and the current pat_sel.
// step and wrap are registered one-cycle strobes that follow each tick edge.
module bar_pattern_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 8,
  localparam int LW   = $clog2(WIDTH),
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             pat_sel,
  output logic [LW-1:0]    level,
  output logic [WIDTH-1:0] out_data,
  output logic             step,
  output logic             wrap
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  // Terminal values use WIDTH, not 2^LW, so odd widths wrap correctly.
  localparam logic [PW-1:0] PMAX    = PW'(DIV - 1);
  localparam logic [LW-1:0] LMAX    = LW'(WIDTH - 1);
  localparam logic [LW-1:0] LMAX_M1 = LW'(WIDTH - 2);
  localparam logic [LW-1:0] LONE    = LW'(1);

  // Ping-pong direction; only ping-pong mode changes it.
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] out_q, out_d;
  dir_t             dir_q, dir_d;
  logic             step_q, wrap_q, wrap_d, tick;

  // Next-state: prescaler, level/direction on tick, pattern from next level.
  always_comb begin
    pcnt_d  = pcnt_q;
    level_d = level_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    out_d   = '0;
    tick    = en && (pcnt_q == PMAX);

    if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end

    if (tick) begin
      case (mode)
        MODE_UP: begin
          if (level_q == LMAX) begin
            level_d = '0;
            wrap_d  = 1'b1;
          end else begin
            level_d = level_q + LONE;
          end
        end
        MODE_DOWN: begin
          if (level_q == '0) begin
            level_d = LMAX;
            wrap_d  = 1'b1;
          end else begin
            level_d = level_q - LONE;
          end
        end
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            if (level_q == LMAX) begin
              level_d = LMAX_M1;
              dir_d   = DIR_DOWN;
              wrap_d  = 1'b1;
            end else begin
              level_d = level_q + LONE;
            end
          end else begin
            if (level_q == '0) begin
              level_d = LONE;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              level_d = level_q - LONE;
            end
          end
        end
        default: begin
          level_d = level_q;
        end
      endcase
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (pat_sel) begin
        out_d[i] = (LW'(i) == level_d);
      end else begin
        out_d[i] = (LW'(i) <= level_d);
      end
    end
  end

  // State registers with asynchronous clear to the reset pattern.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pcnt_q  <= '0;
      level_q <= '0;
      dir_q   <= DIR_UP;
      out_q   <= WIDTH'(1);
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      step_q  <= tick;
      wrap_q  <= wrap_d;
    end
  end

  assign level    = level_q;
  assign out_data = out_q;
  assign step     = step_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_bar_pattern_sequencer.sv
// Testbench for bar_pattern_sequencer: an 8-bit/DIV=4 instance checked
// cycle-by-cycle against a reference model through an expected queue, plus
// a step table and hand-written corner sequences; a 5-bit/DIV=1 instance
// checks odd-width wrap with a continuous step strobe.
module tb_bar_pattern_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int W5 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pat_sel = 1'b0;
  logic [2:0] level;
  logic [7:0] out_data;
  logic       step, wrap;

  logic       clear5 = 1'b1;
  logic       en5 = 1'b0;
  logic [1:0] mode5 = 2'b00;
  logic       pat5 = 1'b0;
  logic [2:0] level5;
  logic [4:0] out5;
  logic       step5, wrap5;

  bar_pattern_sequencer #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .pat_sel(pat_sel),
    .level(level), .out_data(out_data), .step(step), .wrap(wrap)
  );

  bar_pattern_sequencer #(.WIDTH(W5), .DIV(1)) dut5 (
    .clk(clk), .clear(clear5), .en(en5), .mode(mode5), .pat_sel(pat5),
    .level(level5), .out_data(out5), .step(step5), .wrap(wrap5)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // Expected {level, out_data, step, wrap} after each driven edge.
  logic [12:0] exp_q[$];
  logic [12:0] sb_exp;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      checks++;
      if ({level, out_data, step, wrap} !== sb_exp) begin
        errors++;
        $display("FAIL sb_cycle t=%0t got lvl=%0d out=%h step=%b wrap=%b exp lvl=%0d out=%h step=%b wrap=%b",
                 $time, level, out_data, step, wrap,
                 sb_exp[12:10], sb_exp[9:2], sb_exp[1], sb_exp[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_pcnt  = 0;
  int   m_level = 0;
  bit   m_dir   = 1'b0;
  bit   m_step  = 1'b0;
  bit   m_wrap  = 1'b0;
  logic [7:0] m_out = 8'h01;

  task automatic model_edge(input logic clr, input logic e, input logic [1:0] md, input logic ps);
    bit tk;
    if (clr) begin
      m_pcnt = 0; m_level = 0; m_dir = 1'b0; m_step = 1'b0; m_wrap = 1'b0; m_out = 8'h01;
      return;
    end
    tk = e && (m_pcnt == D - 1);
    if (e) m_pcnt = tk ? 0 : m_pcnt + 1;
    m_wrap = 1'b0;
    if (tk) begin
      case (md)
        2'b00: if (m_level == W - 1) begin m_level = 0; m_wrap = 1'b1; end else m_level++;
        2'b01: if (m_level == 0) begin m_level = W - 1; m_wrap = 1'b1; end else m_level--;
        2'b10: begin
          if (!m_dir) begin
            if (m_level == W - 1) begin m_level = W - 2; m_dir = 1'b1; m_wrap = 1'b1; end
            else m_level++;
          end else begin
            if (m_level == 0) begin m_level = 1; m_dir = 1'b0; m_wrap = 1'b1; end
            else m_level--;
          end
        end
        default: ;
      endcase
    end
    m_step = tk;
    for (int i = 0; i < W; i++) m_out[i] = ps ? (i == m_level) : (i <= m_level);
  endtask

  // ---------------- driver ----------------
  // Apply inputs, advance one edge, record the model's expectation.
  task automatic drive_cycle(input logic clr, input logic e, input logic [1:0] md, input logic ps);
    clear = clr; en = e; mode = md; pat_sel = ps;
    model_edge(clr, e, md, ps);
    @(posedge clk);
    exp_q.push_back({3'(m_level), m_out, m_step, m_wrap});
    #1;
  endtask

  // ---------------- step table ----------------
  typedef struct {
    logic [1:0] mode;
    logic       pat;
    logic [2:0] exp_level;
    logic [7:0] exp_out;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs [29];

  initial begin
    vecs = '{
      // up-wrap thermometer from reset
      '{2'b00, 1'b0, 3'd1, 8'h03, 1'b0}, '{2'b00, 1'b0, 3'd2, 8'h07, 1'b0},
      '{2'b00, 1'b0, 3'd3, 8'h0F, 1'b0}, '{2'b00, 1'b0, 3'd4, 8'h1F, 1'b0},
      '{2'b00, 1'b0, 3'd5, 8'h3F, 1'b0}, '{2'b00, 1'b0, 3'd6, 8'h7F, 1'b0},
      '{2'b00, 1'b0, 3'd7, 8'hFF, 1'b0}, '{2'b00, 1'b0, 3'd0, 8'h01, 1'b1},
      // ping-pong from level 0, direction up
      '{2'b10, 1'b0, 3'd1, 8'h03, 1'b0}, '{2'b10, 1'b0, 3'd2, 8'h07, 1'b0},
      '{2'b10, 1'b0, 3'd3, 8'h0F, 1'b0}, '{2'b10, 1'b0, 3'd4, 8'h1F, 1'b0},
      '{2'b10, 1'b0, 3'd5, 8'h3F, 1'b0}, '{2'b10, 1'b0, 3'd6, 8'h7F, 1'b0},
      '{2'b10, 1'b0, 3'd7, 8'hFF, 1'b0}, '{2'b10, 1'b0, 3'd6, 8'h7F, 1'b1},
      '{2'b10, 1'b0, 3'd5, 8'h3F, 1'b0}, '{2'b10, 1'b0, 3'd4, 8'h1F, 1'b0},
      '{2'b10, 1'b0, 3'd3, 8'h0F, 1'b0}, '{2'b10, 1'b0, 3'd2, 8'h07, 1'b0},
      '{2'b10, 1'b0, 3'd1, 8'h03, 1'b0}, '{2'b10, 1'b0, 3'd0, 8'h01, 1'b0},
      '{2'b10, 1'b0, 3'd1, 8'h03, 1'b1}, '{2'b10, 1'b0, 3'd2, 8'h07, 1'b0},
      // down-wrap one-hot from level 2
      '{2'b01, 1'b1, 3'd1, 8'h02, 1'b0}, '{2'b01, 1'b1, 3'd0, 8'h01, 1'b0},
      '{2'b01, 1'b1, 3'd7, 8'h80, 1'b1}, '{2'b01, 1'b1, 3'd6, 8'h40, 1'b0},
      '{2'b01, 1'b1, 3'd5, 8'h20, 1'b0}
    };
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lv;
    #2;
    // Reset state of both instances.
    drive_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out", 64'(out_data), 64'h01);
    chk("rst5_level", 64'(level5), 64'd0);
    chk("rst5_out", 64'(out5), 64'h01);

    // Odd width, DIV=1: continuous step, level 0..4 only.
    clear5 = 1'b0; en5 = 1'b1; mode5 = 2'b00; pat5 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(1'b1, 1'b0, 2'b00, 1'b0);
      lv = k % W5;
      chk("w5_step", 64'(step5), 64'd1);
      chk("w5_level", 64'(level5), 64'(lv));
      chk("w5_wrap", 64'(wrap5), (lv == 0) ? 64'd1 : 64'd0);
      chk("w5_out", 64'(out5), (64'd1 << (lv + 1)) - 64'd1);
    end

    // Table: each record is one DIV-cycle step, checked just after the tick edge.
    for (int v = 0; v < 29; v++) begin
      for (int c = 0; c < D; c++) drive_cycle(1'b0, 1'b1, vecs[v].mode, vecs[v].pat);
      chk("vec_level", 64'(level), 64'(vecs[v].exp_level));
      chk("vec_out", 64'(out_data), 64'(vecs[v].exp_out));
      chk("vec_step", 64'(step), 64'd1);
      chk("vec_wrap", 64'(wrap), 64'(vecs[v].exp_wrap));
    end

    // pat_sel change at level 5 shows on the next edge, level unchanged.
    drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
    chk("patsel_out", 64'(out_data), 64'h3F);
    chk("patsel_level", 64'(level), 64'd5);
    chk("patsel_step", 64'(step), 64'd0);

    // Pause at pcnt=2 for 10 cycles, then the tick lands 2 enabled cycles later.
    drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, 1'b0, 2'b01, 1'b0);
      chk("pause_step", 64'(step), 64'd0);
      chk("pause_level", 64'(level), 64'd5);
    end
    drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
    chk("resume1_step", 64'(step), 64'd0);
    chk("resume1_level", 64'(level), 64'd5);
    drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
    chk("resume2_step", 64'(step), 64'd1);
    chk("resume2_level", 64'(level), 64'd4);
    chk("resume2_out", 64'(out_data), 64'h1F);

    // Climb to level 6, then clear asynchronously while step is high.
    for (int c = 0; c < 2 * D; c++) drive_cycle(1'b0, 1'b1, 2'b00, 1'b0);
    chk("pre_clear_level", 64'(level), 64'd6);
    chk("pre_clear_step", 64'(step), 64'd1);
    @(negedge clk);
    #1;
    clear = 1'b1;
    #1;
    chk("aclr_level", 64'(level), 64'd0);
    chk("aclr_out", 64'(out_data), 64'h01);
    chk("aclr_step", 64'(step), 64'd0);
    drive_cycle(1'b1, 1'b1, 2'b00, 1'b0);

    // After release the first tick is on the DIV-th edge.
    for (int c = 1; c <= D; c++) begin
      drive_cycle(1'b0, 1'b1, 2'b00, 1'b0);
      chk("post_clear_step", 64'(step), (c == D) ? 64'd1 : 64'd0);
      chk("post_clear_level", 64'(level), (c == D) ? 64'd1 : 64'd0);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
